// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// The optional per-requester grant counters are enabled with ALU_SCHED_STATS_EN.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ALU_LAT_MAX = 4;
  localparam int LAT_W       = $clog2(ALU_LAT_MAX);

endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= NREQ_W) begin
        pos = pos - NREQ_W;
      end
      if (!any && req[pos[IW-1:0]]) begin
        any                = 1'b1;
        grant[pos[IW-1:0]] = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one add/sub ALU between NREQ requesters: grant, execute, respond.
// Define ALU_SCHED_STATS_EN to add the saturating grant_cnt counters.
import alu_sched_pkg::*;

module alu_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int ALU_LAT = 1,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ-1:0]     req_op,
  output logic [NREQ-1:0]     req_ready,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic                alu_op,
  input  logic [DW:0]         alu_y,
  output logic                rsp_valid,
  output logic [IW-1:0]       rsp_id,
  output logic [DW:0]         rsp_data,
  input  logic                rsp_ready,
`ifdef ALU_SCHED_STATS_EN
  output logic [NREQ*8-1:0]   grant_cnt,
`endif
  output logic                busy
);

  logic [DW-1:0] a_arr [NREQ];
  logic [DW-1:0] b_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*DW +: DW];
      assign b_arr[gi] = req_b[gi*DW +: DW];
    end
  endgenerate

  sched_state_t     state_reg, state_next;
  logic [LAT_W-1:0] lat_reg, lat_next;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    g_reg;
  logic [DW-1:0]    a_reg, b_reg;
  logic             op_reg;
  logic [DW:0]      data_reg;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
  logic             latch, capture, accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // reset gates the grant so req_ready reads 0 for the whole reset interval.
  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    req_ready  = '0;
    latch      = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any && reset) begin
          req_ready  = grant;
          latch      = 1'b1;
          lat_next   = LAT_W'(ALU_LAT - 1);
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (lat_reg == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          lat_next = lat_reg - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      lat_reg   <= '0;
      ptr_reg   <= '0;
      g_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lat_reg   <= lat_next;
      if (latch) begin
        a_reg  <= a_arr[grant_idx];
        b_reg  <= b_arr[grant_idx];
        op_reg <= req_op[grant_idx];
        g_reg  <= grant_idx;
      end
      if (capture) begin
        data_reg <= alu_y;
      end
      if (accept) begin
        ptr_reg <= (g_reg == IW'(NREQ - 1)) ? '0 : g_reg + 1'b1;
      end
    end
  end

  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_op    = op_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = g_reg;
  assign rsp_data  = data_reg;
  assign busy      = (state_reg != IDLE);

`ifdef ALU_SCHED_STATS_EN
  logic [7:0] cnt_reg [NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stats
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg[gi] <= '0;
        end else if (req_ready[gi] && (cnt_reg[gi] != 8'hFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
        end
      end
      assign grant_cnt[gi*8 +: 8] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one 4-bit add/sub ALU between several requesters. Each requester presents an operand pair and opcode with a valid/ready handshake. The block grants one requester at a time, drives the shared ALU, waits a fixed ALU latency, and returns the result tagged with the requester id over a valid/ready response channel. It sits between the requesting controllers (e.g. the 0-to-8 sequencing controller) and the shared ALU datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 4, operand width
- ALU_LAT, 1, cycles from alu_a/alu_b/alu_op stable to alu_y valid (1..4)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request present, one bit per requester
- req_a  in  NREQ*DW  operand A, requester i at bits [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing
- req_op  in  NREQ  opcode per requester: 0 = add, 1 = subtract
- req_ready  out  NREQ  one-hot grant/accept strobe
- alu_a, alu_b  out  DW each  operands to shared ALU
- alu_op  out  1  opcode to shared ALU
- alu_y  in  DW+1  ALU result with carry/borrow in MSB
- rsp_valid  out  1  response present
- rsp_id  out  $clog2(NREQ)  index of the requester served
- rsp_data  out  DW+1  captured alu_y
- rsp_ready  in  1  response consumer accepts
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, EXEC, RESP (encoding in the package).
- IDLE: if any req_valid, pick the first set bit scanning upward from pointer ptr with wrap-around. req_ready[g] = 1 combinationally in that cycle only. Latch a, b, op and g. Next state EXEC with lat_cnt = ALU_LAT-1.
- EXEC: alu_a/alu_b/alu_op driven from the latched registers. Decrement lat_cnt. When lat_cnt == 0, capture alu_y into rsp_data and go to RESP.
- RESP: rsp_valid = 1. rsp_id and rsp_data are held stable until rsp_ready. On rsp_valid && rsp_ready: set ptr = (g+1) mod NREQ and go to IDLE.
- No grant is issued outside IDLE. req_ready is 0 in EXEC and RESP.
- A requester that drops req_valid before it is granted is simply skipped. There is no retention of unsampled requests.
- alu_a/alu_b/alu_op hold their last latched values in IDLE and RESP.
- Arithmetic is performed in the ALU, not here. The expected result is modulo 2^(DW+1): add = a+b, sub = a-b with two's-complement wrap.

## Timing
- Reset values: req_ready 0, alu_a/alu_b/alu_op 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, ptr 0, state IDLE.
- Cycle sequence:
  - Grant at cycle T.
  - EXEC for cycles T+1 .. T+ALU_LAT.
  - rsp_valid from cycle T+ALU_LAT+1.
- Minimum spacing between grants is ALU_LAT+2 cycles when rsp_ready is held high.
- Reset asserted mid-operation (EXEC or RESP): all outputs go to their reset values immediately. The in-flight request is dropped and its requester must re-issue it.
- rsp_ready while rsp_valid = 0 is ignored.

## Configuration
- ALU_SCHED_STATS_EN defined: adds output grant_cnt (NREQ*8), one saturating 8-bit counter per requester.
  - The counter increments on each req_ready[i] pulse and sticks at 8'hFF.
  - Cleared by reset.
- ALU_SCHED_STATS_EN undefined: no port and no counter logic.

## Structure
- Package alu_sched_pkg holds:
  - state enum (IDLE, EXEC, RESP)
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1
  - the maximum ALU_LAT constant
- One sub-module, rr_arbiter: inputs req vector and ptr, outputs one-hot grant and encoded index. It is purely combinational.
- FSM, latches, latency counter and optional stats stay in the top module.

## Test plan
All scenarios use NREQ=4, DW=4, ALU_LAT=1 and a behavioural ALU model, unless stated otherwise.
- Reset check: hold reset low 15 ns, release → all outputs 0, busy 0, no req_ready for 3 idle cycles.
- Single add: req 0 with a=4'h5, b=4'hB, op=0 → req_ready=4'b0001 at T; rsp_valid at T+2 with rsp_id=0, rsp_data=5'h10.
- Subtract with borrow: req 2 with a=4'h3, b=4'hB, op=1 → rsp_id=2, rsp_data=5'h18.
- Fairness: all four req_valid high continuously, rsp_ready=1 → grants in order 0,1,2,3,0, spaced 3 cycles apart.
- Backpressure: req 1 with a=4'h9, b=4'h4, op=1; rsp_ready=0 for 5 cycles → rsp_valid held with rsp_data=5'h05 and no new grant while req 3 waits. Req 3 is granted in the cycle after rsp_ready is accepted.
- Mid-operation reset: assert reset during EXEC → outputs return to 0 at once; ptr=0, so req 0 is granted first after release. With ALU_SCHED_STATS_EN defined, grant_cnt reads 0.
